cdce62005_init_ctrl: RTL and testbench

Power-up and supervision sequencer for the CDCE62005 clock synthesizer. It sits directly upstream of the CDCE62005 SPI configuration block. It holds that block's `en` low through a power-up delay, then releases it and waits for `cfg_finish`. After that it qualifies the chip's PLL_LOCK pin and asserts `clk_ready` to the ADC datapath. On timeout or lock loss it re-runs configuration by pulsing `en` low, up to a bounded retry count.

---
 rtl/cdce62005_init_ctrl.sv | 157 +++++++++++++++
 tb/tb_cdce62005_init_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdce62005_init_ctrl.sv
// Power-up, configuration and PLL-lock supervision sequencer for the CDCE62005
// clock synthesizer; drives the enable of its SPI configuration block.
module cdce62005_init_ctrl #(
    parameter int POWERUP_CYCLES = 1000000,
    parameter int CFG_TIMEOUT    = 4000000,
    parameter int LOCK_TIMEOUT   = 1000000,
    parameter int LOCK_STABLE    = 10000,
    parameter int GAP_CYCLES     = 16,
    parameter int MAX_RETRY      = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    input  logic       cfg_finish,
    output logic       cfg_en,
    output logic       clk_ready,
    output logic       fail,
    output logic [3:0] retry_cnt,
    output logic [7:0] lock_loss_cnt,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_POWERUP   = 3'd0,
        ST_CFG       = 3'd1,
        ST_LOCK_WAIT = 3'd2,
        ST_READY     = 3'd3,
        ST_GAP       = 3'd4,
        ST_FAIL      = 3'd5
    } state_t;

    localparam logic [31:0] POWERUP_LAST = 32'(POWERUP_CYCLES - 1);
    localparam logic [31:0] CFG_LAST     = 32'(CFG_TIMEOUT - 1);
    localparam logic [31:0] LOCK_LAST    = 32'(LOCK_TIMEOUT - 1);
    localparam logic [31:0] STABLE_LAST  = 32'(LOCK_STABLE - 1);
    localparam logic [31:0] GAP_LAST     = 32'(GAP_CYCLES - 1);
    localparam logic [3:0]  RETRY_LIMIT  = 4'(MAX_RETRY);

    state_t      state_r;
    logic [31:0] timer;
    logic [31:0] stable_cnt;
    logic        lock_meta;
    logic        lock_s;
    logic        lock_qualified;
    logic        retry_req;

    assign state = state_r;

    // PLL_LOCK is asynchronous to clk; only lock_s is used beyond this point.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
        end
    end

    // Handshake with the config block: cfg_en is a level enable (low = held in
    // reset); cfg_finish is only acted on while in CFG, anywhere else it is ignored.
    assign lock_qualified = lock_s && (stable_cnt == STABLE_LAST);

    always_comb begin
        retry_req = 1'b0;
        case (state_r)
            ST_CFG:       retry_req = !cfg_finish && (timer == CFG_LAST);
            ST_LOCK_WAIT: retry_req = !lock_qualified && (timer == LOCK_LAST);
            ST_READY:     retry_req = !lock_s;
            default:      retry_req = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_POWERUP;
            timer         <= '0;
            stable_cnt    <= '0;
            cfg_en        <= 1'b0;
            clk_ready     <= 1'b0;
            fail          <= 1'b0;
            retry_cnt     <= '0;
            lock_loss_cnt <= '0;
        end else begin
            timer <= timer + 32'd1;
            if (retry_req) begin
                // Retry is resolved in a single cycle from CFG, LOCK_WAIT or READY.
                timer     <= '0;
                cfg_en    <= 1'b0;
                clk_ready <= 1'b0;
                if (state_r == ST_READY && lock_loss_cnt != 8'hFF) begin
                    lock_loss_cnt <= lock_loss_cnt + 8'd1;
                end
                if (retry_cnt == RETRY_LIMIT) begin
                    fail    <= 1'b1;
                    state_r <= ST_FAIL;
                end else begin
                    retry_cnt <= retry_cnt + 4'd1;
                    state_r   <= ST_GAP;
                end
            end else begin
                case (state_r)
                    ST_POWERUP: begin
                        if (timer == POWERUP_LAST) begin
                            cfg_en  <= 1'b1;
                            timer   <= '0;
                            state_r <= ST_CFG;
                        end
                    end
                    ST_CFG: begin
                        if (cfg_finish) begin
                            stable_cnt <= '0;
                            timer      <= '0;
                            state_r    <= ST_LOCK_WAIT;
                        end
                    end
                    ST_LOCK_WAIT: begin
                        if (lock_s) begin
                            stable_cnt <= stable_cnt + 32'd1;
                        end else begin
                            stable_cnt <= '0;
                        end
                        if (lock_qualified) begin
                            clk_ready <= 1'b1;
                            timer     <= '0;
                            state_r   <= ST_READY;
                        end
                    end
                    ST_READY: begin
                        cfg_en <= 1'b1;
                    end
                    ST_GAP: begin
                        if (timer == GAP_LAST) begin
                            cfg_en  <= 1'b1;
                            timer   <= '0;
                            state_r <= ST_CFG;
                        end
                    end
                    ST_FAIL: begin
                        cfg_en    <= 1'b0;
                        clk_ready <= 1'b0;
                        fail      <= 1'b1;
                    end
                    default: begin
                        // Unreachable codes park in FAIL with the chip held off.
                        cfg_en    <= 1'b0;
                        clk_ready <= 1'b0;
                        fail      <= 1'b1;
                        timer     <= '0;
                        state_r   <= ST_FAIL;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cdce62005_init_ctrl.sv
// Bench for cdce62005_init_ctrl: directed vector table, hand-timed corner
// sequences and randomized stimulus against a cycle-level reference model.
module tb_cdce62005_init_ctrl;

    localparam int P_PU  = 16;
    localparam int P_CT  = 100;
    localparam int P_LT  = 50;
    localparam int P_LS  = 8;
    localparam int P_GAP = 4;
    localparam int P_MR  = 2;
    localparam int W     = 18;

    localparam int PH_POWERUP   = 0;
    localparam int PH_CFG       = 1;
    localparam int PH_LOCK_WAIT = 2;
    localparam int PH_READY     = 3;
    localparam int PH_GAP       = 4;
    localparam int PH_FAIL      = 5;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b1;
    logic       pll_lock   = 1'b0;
    logic       cfg_finish = 1'b0;
    logic       cfg_en;
    logic       clk_ready;
    logic       fail;
    logic [3:0] retry_cnt;
    logic [7:0] lock_loss_cnt;
    logic [2:0] state;

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];

    // Reference model: phase plus the edge index at which it was entered.
    int m_phase;
    int m_entry;
    int m_k;
    int m_retries;
    int m_losses;
    bit m_cfg_en;
    bit m_ready;
    bit m_fail;
    bit pin_hist[$];

    typedef struct {
        int           cycles;
        bit           pl;
        bit           fin;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs[16];

    cdce62005_init_ctrl #(
        .POWERUP_CYCLES(P_PU),
        .CFG_TIMEOUT   (P_CT),
        .LOCK_TIMEOUT  (P_LT),
        .LOCK_STABLE   (P_LS),
        .GAP_CYCLES    (P_GAP),
        .MAX_RETRY     (P_MR)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pll_lock     (pll_lock),
        .cfg_finish   (cfg_finish),
        .cfg_en       (cfg_en),
        .clk_ready    (clk_ready),
        .fail         (fail),
        .retry_cnt    (retry_cnt),
        .lock_loss_cnt(lock_loss_cnt),
        .state        (state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached without summary, expected self-termination");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic logic [W-1:0] mk(input int st, input bit en, input bit rdy,
                                        input bit f, input int rc, input int lc);
        return {3'(st), en, rdy, f, 4'(rc), 8'(lc)};
    endfunction

    function automatic string fmt(input logic [W-1:0] v);
        return $sformatf("state=%0d cfg_en=%0b clk_ready=%0b fail=%0b retry_cnt=%0d lock_loss_cnt=%0d",
                         v[17:15], v[14], v[13], v[12], v[11:8], v[7:0]);
    endfunction

    task automatic expect_vec(input string name, input logic [W-1:0] exp_v);
        logic [W-1:0] got;
        got = {state, cfg_en, clk_ready, fail, retry_cnt, lock_loss_cnt};
        checks++;
        if (got !== exp_v) begin
            failures++;
            $display("FAIL %s: got %s, expected %s", name, fmt(got), fmt(exp_v));
        end
    endtask

    // ---------------- reference model ----------------
    // lock_s seen at edge k is the pin value driven before edge k-2.
    function automatic bit lock_s_at(input int k);
        if (k < 3) return 1'b0;
        return pin_hist[k-3];
    endfunction

    function automatic void enter(input int ph);
        m_phase = ph;
        m_entry = m_k;
    endfunction

    function automatic void model_retry();
        m_cfg_en = 1'b0;
        m_ready  = 1'b0;
        if (m_retries == P_MR) begin
            m_fail = 1'b1;
            enter(PH_FAIL);
        end else begin
            m_retries++;
            enter(PH_GAP);
        end
    endfunction

    function automatic void model_reset();
        m_phase   = PH_POWERUP;
        m_entry   = 0;
        m_k       = 0;
        m_retries = 0;
        m_losses  = 0;
        m_cfg_en  = 1'b0;
        m_ready   = 1'b0;
        m_fail    = 1'b0;
        pin_hist.delete();
        exp_q.delete();
    endfunction

    function automatic void model_edge(input bit fin);
        int run;
        m_k++;
        case (m_phase)
            PH_POWERUP: if (m_k - m_entry == P_PU) begin m_cfg_en = 1'b1; enter(PH_CFG); end
            PH_CFG: begin
                if (fin) enter(PH_LOCK_WAIT);
                else if (m_k - m_entry == P_CT) model_retry();
            end
            PH_LOCK_WAIT: begin
                run = 0;
                for (int j = m_k; j > m_entry && lock_s_at(j); j--) run++;
                if (run == P_LS) begin m_ready = 1'b1; enter(PH_READY); end
                else if (m_k - m_entry == P_LT) model_retry();
            end
            PH_READY: begin
                if (!lock_s_at(m_k)) begin
                    if (m_losses < 255) m_losses++;
                    model_retry();
                end
            end
            PH_GAP: if (m_k - m_entry == P_GAP) begin m_cfg_en = 1'b1; enter(PH_CFG); end
            default: ;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick(input bit pl, input bit fin);
        logic [W-1:0] exp_v;
        pll_lock   = pl;
        cfg_finish = fin;
        pin_hist.push_back(pl);
        model_edge(fin);
        exp_q.push_back({3'(m_phase), m_cfg_en, m_ready, m_fail, 4'(m_retries), 8'(m_losses)});
        @(posedge clk);
        #1;
        exp_v = exp_q.pop_front();
        expect_vec($sformatf("model@edge%0d", m_k), exp_v);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        expect_vec("async_reset", mk(0, 0, 0, 0, 0, 0));
        model_reset();
        pll_lock   = 1'b0;
        cfg_finish = 1'b0;
        repeat (2) @(negedge clk);
        expect_vec("reset_held", mk(0, 0, 0, 0, 0, 0));
        rst_n = 1'b1;
    endtask

    // ---------------- test ----------------
    initial begin
        // Nominal bring-up, lock loss, GAP with stray cfg_finish, lock chatter.
        vecs[0]  = '{15, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0)};
        vecs[1]  = '{1,  1'b0, 1'b0, mk(1, 1, 0, 0, 0, 0)};
        vecs[2]  = '{14, 1'b0, 1'b0, mk(1, 1, 0, 0, 0, 0)};
        vecs[3]  = '{5,  1'b0, 1'b1, mk(2, 1, 0, 0, 0, 0)};
        vecs[4]  = '{9,  1'b1, 1'b1, mk(2, 1, 0, 0, 0, 0)};
        vecs[5]  = '{1,  1'b1, 1'b1, mk(3, 1, 1, 0, 0, 0)};
        vecs[6]  = '{5,  1'b1, 1'b0, mk(3, 1, 1, 0, 0, 0)};
        vecs[7]  = '{2,  1'b0, 1'b0, mk(3, 1, 1, 0, 0, 0)};
        vecs[8]  = '{1,  1'b0, 1'b0, mk(4, 0, 0, 0, 1, 1)};
        vecs[9]  = '{3,  1'b0, 1'b1, mk(4, 0, 0, 0, 1, 1)};
        vecs[10] = '{1,  1'b0, 1'b1, mk(1, 1, 0, 0, 1, 1)};
        vecs[11] = '{1,  1'b0, 1'b1, mk(2, 1, 0, 0, 1, 1)};
        vecs[12] = '{5,  1'b1, 1'b0, mk(2, 1, 0, 0, 1, 1)};
        vecs[13] = '{1,  1'b0, 1'b0, mk(2, 1, 0, 0, 1, 1)};
        vecs[14] = '{9,  1'b1, 1'b0, mk(2, 1, 0, 0, 1, 1)};
        vecs[15] = '{1,  1'b1, 1'b0, mk(3, 1, 1, 0, 1, 1)};

        apply_reset();
        for (int i = 0; i < 16; i++) begin
            repeat (vecs[i].cycles) tick(vecs[i].pl, vecs[i].fin);
            expect_vec($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Asynchronous reset while READY, then CFG-timeout exhaustion.
        repeat (3) tick(1'b1, 1'b0);
        expect_vec("ready_hold", mk(3, 1, 1, 0, 1, 1));
        apply_reset();
        repeat (15) tick(1'b0, 1'b0);
        expect_vec("pu_edge15", mk(0, 0, 0, 0, 0, 0));
        tick(1'b0, 1'b0);
        expect_vec("pu_edge16", mk(1, 1, 0, 0, 0, 0));
        repeat (99) tick(1'b0, 1'b0);
        expect_vec("cfg_to_edge115", mk(1, 1, 0, 0, 0, 0));
        tick(1'b0, 1'b0);
        expect_vec("cfg_to_retry1", mk(4, 0, 0, 0, 1, 0));
        repeat (3) tick(1'b0, 1'b0);
        expect_vec("gap1_low", mk(4, 0, 0, 0, 1, 0));
        tick(1'b0, 1'b0);
        expect_vec("gap1_exit", mk(1, 1, 0, 0, 1, 0));
        repeat (100) tick(1'b0, 1'b0);
        expect_vec("cfg_to_retry2", mk(4, 0, 0, 0, 2, 0));
        repeat (4) tick(1'b0, 1'b0);
        expect_vec("gap2_exit", mk(1, 1, 0, 0, 2, 0));
        repeat (99) tick(1'b0, 1'b0);
        expect_vec("cfg_to_edge323", mk(1, 1, 0, 0, 2, 0));
        tick(1'b0, 1'b0);
        expect_vec("cfg_to_fail", mk(5, 0, 0, 1, 2, 0));
        repeat (30) tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        expect_vec("fail_sticky", mk(5, 0, 0, 1, 2, 0));

        // LOCK_TIMEOUT, then two READY lock losses ending in FAIL.
        apply_reset();
        repeat (16) tick(1'b0, 1'b0);
        expect_vec("pu_restart", mk(1, 1, 0, 0, 0, 0));
        tick(1'b0, 1'b1);
        expect_vec("lock_wait_entry", mk(2, 1, 0, 0, 0, 0));
        repeat (49) tick(1'b0, 1'b0);
        expect_vec("lock_to_edge49", mk(2, 1, 0, 0, 0, 0));
        tick(1'b0, 1'b0);
        expect_vec("lock_to_retry", mk(4, 0, 0, 0, 1, 0));
        repeat (4) tick(1'b0, 1'b0);
        expect_vec("lock_to_gap_exit", mk(1, 1, 0, 0, 1, 0));
        tick(1'b1, 1'b1);
        repeat (9) tick(1'b1, 1'b0);
        expect_vec("relock_ready", mk(3, 1, 1, 0, 1, 0));
        repeat (3) tick(1'b0, 1'b0);
        expect_vec("loss2_retry", mk(4, 0, 0, 0, 2, 1));
        repeat (4) tick(1'b1, 1'b0);
        expect_vec("loss2_gap_exit", mk(1, 1, 0, 0, 2, 1));
        tick(1'b1, 1'b1);
        repeat (8) tick(1'b1, 1'b0);
        expect_vec("relock2_ready", mk(3, 1, 1, 0, 2, 1));
        repeat (3) tick(1'b0, 1'b0);
        expect_vec("loss3_fail", mk(5, 0, 0, 1, 2, 2));
        repeat (10) tick(1'b1, 1'b1);
        expect_vec("loss3_fail_hold", mk(5, 0, 0, 1, 2, 2));

        // Randomized runs checked cycle by cycle against the model.
        for (int r = 0; r < 6; r++) begin
            int flip_div;
            int fin_div;
            bit pl;
            bit fin;
            apply_reset();
            flip_div = $urandom_range(4, 30);
            fin_div  = $urandom_range(2, 60);
            pl = 1'b0;
            for (int c = 0; c < 450; c++) begin
                if ($urandom_range(0, flip_div - 1) == 0) pl = ~pl;
                fin = ($urandom_range(0, fin_div - 1) == 0);
                tick(pl, fin);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
